// File: rtl/cpu_run_controller.sv
// cpu_run_controller
// Run-control and verdict block for the riscv_cpu core. It holds the core in
// reset for RST_HOLD cycles, then releases it and watches cpu_dummy_out for
// a pass signature (STABLE consecutive cycles) or a fail signature. If neither
// appears, the run ends with a timeout after TIMEOUT cycles. The verdict stays
// valid in DONE until a new start or rst, so runs can repeat without a global
// reset.
//
// Handshake: start is a level sampled on every rising edge. It is acted on only
// in IDLE or DONE and ignored in HOLD and RUN. There is no ready/ack; busy and
// done report progress.
//
// dbg_state exposes the FSM state for checkers: 0=IDLE, 1=HOLD, 2=RUN, 3=DONE.
module cpu_run_controller #(
    parameter int                 DATA_W   = 32,
    parameter int                 CNT_W    = 32,
    parameter int                 RST_HOLD = 5,
    parameter int                 STABLE   = 4,
    parameter int                 TIMEOUT  = 1000,
    parameter logic [DATA_W-1:0]  PASS_SIG = DATA_W'(32'h600D_600D),
    parameter logic [DATA_W-1:0]  FAIL_SIG = DATA_W'(32'hBAD0_BAD0)
) (
    input  logic              clk_150_mhz,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] cpu_dummy_out,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Counter widths are sized so the terminal values fit without overflow.
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    localparam int STB_W  = $clog2(STABLE + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
    localparam logic [STB_W-1:0]  STABLE_N  = STB_W'(STABLE);
    localparam logic [CNT_W-1:0]  TIMEOUT_N = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [STB_W-1:0]   stable_q, stable_d;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   count_inc;
    logic [STB_W-1:0]   stable_inc;
    logic               pass_d, fail_d, timeout_d;
    logic               cpu_rst_n_d, busy_d, done_d;
    logic               sig_fail, sig_pass, pass_hit, time_hit;

    // Next-state, counter and verdict logic; every output is derived from the
    // next state so that all ports come straight from flops.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stable_d    = stable_q;
        count_d     = cycle_count;
        pass_d      = pass;
        fail_d      = fail;
        timeout_d   = timeout;
        count_inc   = cycle_count + CNT_W'(1);
        stable_inc  = stable_q + STB_W'(1);
        sig_fail    = (cpu_dummy_out == FAIL_SIG);
        sig_pass    = (cpu_dummy_out == PASS_SIG);
        pass_hit    = sig_pass && (stable_inc == STABLE_N);
        time_hit    = (count_inc == TIMEOUT_N);

        case (state_q)
            S_IDLE, S_DONE: begin
                // A new run clears the previous verdict on HOLD entry.
                if (start) begin
                    state_d   = S_HOLD;
                    hold_d    = '0;
                    stable_d  = '0;
                    count_d   = '0;
                    pass_d    = 1'b0;
                    fail_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            S_RUN: begin
                count_d  = count_inc;
                stable_d = sig_pass ? stable_inc : '0;
                // Verdict priority: fail, then pass, then timeout.
                if (sig_fail) begin
                    fail_d  = 1'b1;
                    state_d = S_DONE;
                end else if (pass_hit) begin
                    pass_d  = 1'b1;
                    state_d = S_DONE;
                end else if (time_hit) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cpu_rst_n_d = (state_d == S_RUN);
        busy_d      = (state_d == S_HOLD) || (state_d == S_RUN);
        done_d      = (state_d == S_DONE);
    end

    // State, counters and registered outputs; rst returns everything to IDLE.
    always_ff @(posedge clk_150_mhz) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            stable_q    <= '0;
            cycle_count <= '0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            cpu_rst_n   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stable_q    <= stable_d;
            cycle_count <= count_d;
            pass        <= pass_d;
            fail        <= fail_d;
            timeout     <= timeout_d;
            cpu_rst_n   <= cpu_rst_n_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller. Two instances share the clock
// and reset: a main one with TIMEOUT=64, and a priority one where PASS_SIG
// equals FAIL_SIG and STABLE=1. Verdict records are queued when a run starts
// and compared when done rises.
module tb_cpu_run_controller;

    localparam int          DATA_W   = 32;
    localparam int          CNT_W    = 32;
    localparam int          RST_HOLD = 5;
    localparam int          STABLE   = 4;
    localparam int          TIMEOUT  = 64;
    localparam logic [31:0] PASS_SIG = 32'h600D_600D;
    localparam logic [31:0] FAIL_SIG = 32'hBAD0_BAD0;
    localparam int          EXP_W    = 3 + CNT_W;

    // Clock and reset
    logic clk_150_mhz = 1'b0;
    always #5 clk_150_mhz = ~clk_150_mhz;
    logic rst = 1'b1;

    // Main instance
    logic              start = 1'b0;
    logic [DATA_W-1:0] dout  = '0;
    logic              cpu_rst_n, busy, done, pass, fail, timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [1:0]        dbg_state;

    // Priority instance
    logic              start_b = 1'b0;
    logic [DATA_W-1:0] dout_b  = '0;
    logic              cpu_rst_n_b, busy_b, done_b, pass_b, fail_b, timeout_b;
    logic [CNT_W-1:0]  cycle_count_b;
    logic [1:0]        dbg_state_b;

    cpu_run_controller #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .STABLE(STABLE),
        .TIMEOUT(TIMEOUT), .PASS_SIG(PASS_SIG), .FAIL_SIG(FAIL_SIG)
    ) dut (
        .clk_150_mhz(clk_150_mhz), .rst(rst), .start(start), .cpu_dummy_out(dout),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .pass(pass), .fail(fail),
        .timeout(timeout), .cycle_count(cycle_count), .dbg_state(dbg_state)
    );

    cpu_run_controller #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .RST_HOLD(RST_HOLD), .STABLE(1),
        .TIMEOUT(TIMEOUT), .PASS_SIG(FAIL_SIG), .FAIL_SIG(FAIL_SIG)
    ) dut_b (
        .clk_150_mhz(clk_150_mhz), .rst(rst), .start(start_b), .cpu_dummy_out(dout_b),
        .cpu_rst_n(cpu_rst_n_b), .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
        .timeout(timeout_b), .cycle_count(cycle_count_b), .dbg_state(dbg_state_b)
    );

    // Scoreboard
    int vectors     = 0;
    int miscompares = 0;
    logic [EXP_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [EXP_W-1:0] mk(input bit p, input bit f, input bit t, input int c);
        return {p, f, t, CNT_W'(c)};
    endfunction

    // Core output for RUN cycle n; noise stays below 0x10000 so it never
    // matches either signature.
    function automatic logic [31:0] pat(input int n, input int pass_from, input int gap_at,
                                        input int fail_at);
        if (fail_at != 0 && n == fail_at) return FAIL_SIG;
        if (pass_from != 0 && n >= pass_from) return (n == gap_at) ? 32'h0 : PASS_SIG;
        return 32'($urandom_range(0, 32'h0000_FFFF));
    endfunction

    // Driver: one run on the main instance, starting at a negedge with the
    // DUT in IDLE or DONE. abort_at != 0 pulses rst at that RUN cycle.
    task automatic do_run(input int pass_from, input int gap_at, input int fail_at,
                          input int abort_at, input bit poke, input logic [EXP_W-1:0] exp);
        int hold_n;
        int n;
        logic [EXP_W-1:0] want;
        if (abort_at == 0) exp_q.push_back(exp);
        start = 1'b1;
        @(negedge clk_150_mhz);
        start = 1'b0;
        check("hold_busy", busy, 1);
        check("hold_rst_n", cpu_rst_n, 0);
        check("hold_clear", {done, pass, fail, timeout}, 0);
        check("hold_count", cycle_count, 0);
        hold_n = 0;
        while (!cpu_rst_n && hold_n < 20) begin
            start = poke && (hold_n == 1);
            @(negedge clk_150_mhz);
            hold_n++;
        end
        start = 1'b0;
        check("hold_len", hold_n, RST_HOLD);
        check("run_busy", busy, 1);
        n = 0;
        while (!done && n < 200) begin
            n++;
            dout  = pat(n, pass_from, gap_at, fail_at);
            start = poke && (n == 3);
            rst   = (abort_at != 0) && (n == abort_at);
            @(negedge clk_150_mhz);
            if (rst) begin
                rst   = 1'b0;
                start = 1'b0;
                check("abort_state", dbg_state, 0);
                check("abort_rst_n", cpu_rst_n, 0);
                check("abort_flags", {busy, done, pass, fail, timeout}, 0);
                check("abort_count", cycle_count, 0);
                return;
            end
        end
        start = 1'b0;
        check("done_seen", done, 1);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            want = exp_q.pop_front();
            check("verdict", {pass, fail, timeout, cycle_count}, want);
            check("done_cycle", n, want[CNT_W-1:0]);
            check("done_outs", {busy, cpu_rst_n, dbg_state}, {2'b00, 2'd3});
        end
    endtask

    initial begin
        int pf;
        int fa;
        int n;
        logic [EXP_W-1:0] want;

        // Reset with start held high: start must not win.
        rst     = 1'b1;
        start   = 1'b1;
        start_b = 1'b1;
        repeat (3) @(negedge clk_150_mhz);
        check("rst_state", dbg_state, 0);
        check("rst_rst_n", cpu_rst_n, 0);
        check("rst_flags", {busy, done, pass, fail, timeout}, 0);
        check("rst_count", cycle_count, 0);
        check("rst_state_b", dbg_state_b, 0);
        rst     = 1'b0;
        start   = 1'b0;
        start_b = 1'b0;
        @(negedge clk_150_mhz);
        check("idle_stays", {dbg_state, busy, cpu_rst_n}, 0);

        // Pass from RUN cycle 10.
        do_run(10, 0, 0, 0, 1'b0, mk(1, 0, 0, 13));
        // Interrupted pass from DONE, with start poked during HOLD and RUN.
        do_run(5, 8, 0, 0, 1'b1, mk(1, 0, 0, 12));
        // Pass burst broken by fail before STABLE is reached.
        do_run(4, 0, 7, 0, 1'b0, mk(0, 1, 0, 7));
        // Timeout.
        do_run(0, 0, 0, 0, 1'b0, mk(0, 0, 1, TIMEOUT));
        repeat (3) @(negedge clk_150_mhz);
        check("done_hold", {done, pass, fail, timeout, cycle_count}, {4'b1001, CNT_W'(TIMEOUT)});
        // Abort at RUN cycle 20, then restart from IDLE.
        do_run(0, 0, 0, 20, 1'b0, '0);
        @(negedge clk_150_mhz);
        check("abort_idle", {dbg_state, cpu_rst_n}, 0);
        pf = $urandom_range(1, 40);
        do_run(pf, 0, 0, 0, 1'b0, mk(1, 0, 0, pf + 3));
        fa = $urandom_range(1, 60);
        do_run(0, 0, fa, 0, 1'b0, mk(0, 1, 0, fa));

        // Priority instance: a word matching both signatures resolves to fail.
        exp_q.push_back(mk(0, 1, 0, 3));
        start_b = 1'b1;
        @(negedge clk_150_mhz);
        start_b = 1'b0;
        n = 0;
        while (!cpu_rst_n_b && n < 20) begin
            @(negedge clk_150_mhz);
            n++;
        end
        check("b_hold_len", n, RST_HOLD);
        n = 0;
        while (!done_b && n < 200) begin
            n++;
            dout_b = (n == 3) ? FAIL_SIG : 32'($urandom_range(0, 32'h0000_FFFF));
            @(negedge clk_150_mhz);
        end
        check("b_done_seen", done_b, 1);
        if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
        end else begin
            want = exp_q.pop_front();
            check("b_verdict", {pass_b, fail_b, timeout_b, cycle_count_b}, want);
        end
        check("sb_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Overall time limit in case a bounded loop is bypassed.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Synthesizable run-control and verdict block that sits between the board/bench and the riscv_cpu core.
- Generates the core's active-low reset pulse with a programmable hold length, then releases the core.
- While the core runs, it counts cycles and watches the core's dummy_out bus for a pass or fail signature.
- Reports pass, fail or timeout, which makes fixed-delay bench stimulus unnecessary and allows repeated runs without a global reset.

Parameters:
- DATA_W, 32: width of the observed core output bus.
- CNT_W, 32: width of the run cycle counter.
- RST_HOLD, 5: number of cycles cpu_rst_n is held low after start; must be >= 1.
- STABLE, 4: number of consecutive cycles PASS_SIG must be seen to declare pass; must be >= 1.
- TIMEOUT, 1000: number of RUN cycles without a verdict before timeout; must be >= 1 and < 2^CNT_W.
- PASS_SIG, 32'h600D_600D: pass signature, compared on DATA_W bits.
- FAIL_SIG, 32'hBAD0_BAD0: fail signature, compared on DATA_W bits.

Ports:
- clk_150_mhz, in, 1: single system clock; all logic is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: run request, sampled each cycle; accepted only in IDLE or DONE.
- cpu_dummy_out, in, DATA_W: observed core output bus.
- cpu_rst_n, out, 1: registered active-low reset to the core.
- busy, out, 1: high in HOLD or RUN.
- done, out, 1: high in DONE.
- pass, out, 1: verdict, pass.
- fail, out, 1: verdict, FAIL_SIG seen.
- timeout, out, 1: verdict, TIMEOUT reached.
- cycle_count, out, CNT_W: number of RUN cycles completed in the current or last run.

Behaviour:
- Reset: on any edge with rst=1 the state becomes IDLE and:
  - cpu_rst_n=0, busy=0, done=0, pass=0, fail=0, timeout=0, cycle_count=0.
  - Internal hold and stable counters are 0.
  - rst overrides start and applies mid-run: the core is re-held on the next edge.
- FSM has four states: IDLE, HOLD, RUN, DONE. All outputs are registered.
- IDLE: cpu_rst_n=0. start=1 at edge k moves to HOLD, so busy=1 after edge k.
- HOLD:
  - cpu_rst_n=0.
  - On entry: hold counter, cycle_count, stable counter and all verdict flags are cleared.
  - HOLD lasts exactly RST_HOLD cycles, then moves to RUN; cpu_rst_n=1 after edge k+RST_HOLD.
  - start is ignored.
- RUN: cpu_rst_n=1 and start is ignored. Each cycle:
  - cycle_count increments by 1.
  - If cpu_dummy_out==FAIL_SIG: go to DONE with fail=1.
  - Else if cpu_dummy_out==PASS_SIG: stable counter increments; when it reaches STABLE, go to DONE with pass=1.
  - Else: stable counter is cleared to 0. A non-consecutive pass pattern never passes.
  - If neither verdict fires and cycle_count reaches TIMEOUT, go to DONE with timeout=1.
  - Priority when several fire in the same cycle: fail > pass > timeout.
  - Exactly one verdict flag is high in DONE.
- DONE:
  - done=1, busy=0, cpu_rst_n=0 (core frozen in reset).
  - Verdict flags and cycle_count hold until start or rst.
  - start=1 goes to HOLD and clears them on entry, giving a back-to-back run.
- cycle_count:
  - Never wraps; TIMEOUT < 2^CNT_W guarantees exit first.
  - In DONE it equals the number of RUN cycles including the verdict cycle.
- cpu_dummy_out is sampled only in RUN; its value in IDLE, HOLD and DONE is don't-care.
- A PASS_SIG followed by FAIL_SIG before STABLE is reached ends as fail, not pass.

Test Plan:
1. rst=1 for 3 cycles, start=1 held -> state IDLE, cpu_rst_n=0, all flags 0, cycle_count=0.
2. Pass run:
   - Stimulus: start pulse at edge k; cpu_dummy_out=0 until cpu_rst_n rises, then PASS_SIG from RUN cycle 10 on.
   - Required: cpu_rst_n=1 after edge k+5; done=1, pass=1, cycle_count=13 after the 4th consecutive match; cpu_rst_n=0 in DONE.
3. Interrupted pass:
   - Stimulus: PASS_SIG for 3 cycles, one cycle of 0, then PASS_SIG steady.
   - Required: no pass after the first burst; pass asserts only after 4 new consecutive matches.
4. Fail and priority:
   - FAIL_SIG at RUN cycle 7 -> fail=1, pass=0, cycle_count=7.
   - Bench with PASS_SIG==FAIL_SIG, STABLE=1 -> fail wins.
5. Timeout with TIMEOUT=64 and cpu_dummy_out=0 throughout -> timeout=1 exactly when cycle_count=64, then done=1.
6. Abort and restart:
   - rst=1 at RUN cycle 20 -> IDLE, cpu_rst_n=0 next edge.
   - start in DONE -> flags cleared on HOLD entry, new 5-cycle hold, run repeats.
   - start during HOLD or RUN -> no effect.
